atm_ledger_arbiter: RTL and testbench

Shares the single-port account balance RAM between NUM_TERM ATM terminal controllers. Each terminal issues a balance query or a debit; the arbiter grants one terminal at a time in round-robin order and performs an atomic read-check-write on the addressed account. It returns the balance and an error flag. It sits between the per-terminal ATM state machines and the shared balance RAM, so two terminals can never interleave updates to the same account.

---
 rtl/atm_pkg.sv | 19 +
 rtl/atm_ledger_arbiter_if.sv | 51 +++++
 rtl/atm_rr_arbiter.sv | 30 +++
 rtl/atm_ledger_arbiter.sv | 151 +++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types and default widths for the ATM ledger arbiter and the terminal controllers.
package atm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StEval,
    StWb,
    StRsp
  } state_e;

  localparam logic OpBalance = 1'b0;
  localparam logic OpDebit   = 1'b1;

  localparam int unsigned DefAcctW   = 4;
  localparam int unsigned DefBalW    = 5;
  localparam int unsigned DefNumAcct = 10;

endpackage

// File: rtl/atm_ledger_arbiter_if.sv
// Terminal-side and RAM-side bus of the ledger arbiter.
// ATM_LEDGER_STATS_EN adds the debit_count statistics output.
interface atm_ledger_arbiter_if
  import atm_pkg::*;
#(
  parameter int unsigned NumTerm = 4,
  parameter int unsigned AcctW   = DefAcctW,
  parameter int unsigned BalW    = DefBalW
);

  logic [NumTerm-1:0]       req;
  logic [NumTerm-1:0]       op;
  logic [NumTerm*AcctW-1:0] req_id;
  logic [NumTerm*BalW-1:0]  req_value;
  logic [NumTerm-1:0]       grant;
  logic [NumTerm-1:0]       done;
  logic [BalW-1:0]          rsp_balance;
  logic                     rsp_err;
  logic [AcctW-1:0]         ram_addr;
  logic                     ram_rd_en;
  logic [BalW-1:0]          ram_rd_data;
  logic                     ram_wr_en;
  logic [BalW-1:0]          ram_wr_data;

`ifdef ATM_LEDGER_STATS_EN
  logic [15:0]              debit_count;

  modport slave (
    input  req, op, req_id, req_value, ram_rd_data,
    output grant, done, rsp_balance, rsp_err, ram_addr, ram_rd_en, ram_wr_en, ram_wr_data,
    output debit_count
  );

  modport master (
    output req, op, req_id, req_value, ram_rd_data,
    input  grant, done, rsp_balance, rsp_err, ram_addr, ram_rd_en, ram_wr_en, ram_wr_data,
    input  debit_count
  );
`else
  modport slave (
    input  req, op, req_id, req_value, ram_rd_data,
    output grant, done, rsp_balance, rsp_err, ram_addr, ram_rd_en, ram_wr_en, ram_wr_data
  );

  modport master (
    output req, op, req_id, req_value, ram_rd_data,
    input  grant, done, rsp_balance, rsp_err, ram_addr, ram_rd_en, ram_wr_en, ram_wr_data
  );
`endif

endinterface

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr wins.
module atm_rr_arbiter #(
  parameter int unsigned NumTerm = 4,
  localparam int unsigned IdxW = (NumTerm > 1) ? $clog2(NumTerm) : 1
) (
  input  logic [NumTerm-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NumTerm-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NumTerm; off++) begin
      cand = IdxW'((32'(ptr) + off) % NumTerm);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter doing an atomic read-check-write on the shared balance RAM.
// ATM_LEDGER_STATS_EN adds a saturating count of successful debits.
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned NumTerm = 4,
  parameter int unsigned AcctW   = DefAcctW,
  parameter int unsigned BalW    = DefBalW,
  parameter int unsigned NumAcct = DefNumAcct
) (
  input logic                  clock,
  input logic                  clear_n,
  atm_ledger_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = (NumTerm > 1) ? $clog2(NumTerm) : 1;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q, win_q;
  logic            op_q, bad_q, err_q;
  logic [AcctW-1:0] id_q;
  logic [BalW-1:0] val_q, res_q;

  logic [NumTerm-1:0] rr_gnt;
  logic [IdxW-1:0]    rr_idx;
  logic               rr_valid;

  logic [AcctW-1:0] sel_id;
  logic [BalW-1:0]  sel_val;
  logic             sel_bad;
  logic             eval_err, eval_wr;
  logic [BalW-1:0]  eval_res;

  atm_rr_arbiter #(
    .NumTerm(NumTerm)
  ) u_rr (
    .req  (bus.req),
    .ptr  (ptr_q),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .valid(rr_valid)
  );

  always_comb begin
    sel_id  = bus.req_id[rr_idx*AcctW +: AcctW];
    sel_val = bus.req_value[rr_idx*BalW +: BalW];
    sel_bad = 32'(sel_id) >= NumAcct;
  end

  // Read data arrives in EVAL, one cycle after the RD strobe.
  always_comb begin
    eval_err = 1'b0;
    eval_res = bus.ram_rd_data;
    if (bad_q) begin
      eval_err = 1'b1;
      eval_res = '0;
    end else if (op_q == OpDebit) begin
      if (bus.ram_rd_data >= val_q) begin
        eval_res = bus.ram_rd_data - val_q;
      end else begin
        eval_err = 1'b1;
      end
    end
    eval_wr = (op_q == OpDebit) && !eval_err;
  end

`ifdef ATM_LEDGER_STATS_EN
  logic [15:0] debit_count_q;
  assign bus.debit_count = debit_count_q;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q         <= StIdle;
      ptr_q           <= IdxW'(NumTerm - 1);
      win_q           <= '0;
      op_q            <= 1'b0;
      bad_q           <= 1'b0;
      err_q           <= 1'b0;
      id_q            <= '0;
      val_q           <= '0;
      res_q           <= '0;
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.rsp_balance <= '0;
      bus.rsp_err     <= 1'b0;
      bus.ram_addr    <= '0;
      bus.ram_rd_en   <= 1'b0;
      bus.ram_wr_en   <= 1'b0;
      bus.ram_wr_data <= '0;
`ifdef ATM_LEDGER_STATS_EN
      debit_count_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rr_valid) begin
            state_q       <= StRd;
            win_q         <= rr_idx;
            op_q          <= bus.op[rr_idx];
            id_q          <= sel_id;
            val_q         <= sel_val;
            bad_q         <= sel_bad;
            bus.grant     <= rr_gnt;
            bus.ram_rd_en <= !sel_bad;
            bus.ram_addr  <= sel_bad ? '0 : sel_id;
          end
        end
        StRd: begin
          state_q       <= StEval;
          bus.ram_rd_en <= 1'b0;
          bus.ram_addr  <= '0;
        end
        StEval: begin
          state_q       <= StWb;
          res_q         <= eval_res;
          err_q         <= eval_err;
          bus.ram_wr_en <= eval_wr;
          if (eval_wr) begin
            bus.ram_addr    <= id_q;
            bus.ram_wr_data <= eval_res;
          end
        end
        StWb: begin
          state_q         <= StRsp;
          bus.ram_wr_en   <= 1'b0;
          bus.ram_addr    <= '0;
          bus.ram_wr_data <= '0;
          bus.done        <= bus.grant;
          bus.rsp_balance <= res_q;
          bus.rsp_err     <= err_q;
`ifdef ATM_LEDGER_STATS_EN
          if (bus.ram_wr_en && debit_count_q != 16'hFFFF) begin
            debit_count_q <= debit_count_q + 16'd1;
          end
`endif
        end
        StRsp: begin
          state_q         <= StIdle;
          ptr_q           <= win_q;
          bus.done        <= '0;
          bus.grant       <= '0;
          bus.rsp_balance <= '0;
          bus.rsp_err     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed, table-driven bench for atm_ledger_arbiter with a behavioural balance RAM.
module tb_atm_ledger_arbiter;
  import atm_pkg::*;

  localparam int unsigned NT = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = 5;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  atm_ledger_arbiter_if #(.NumTerm(NT), .AcctW(AW), .BalW(BW)) bus ();

  atm_ledger_arbiter #(
    .NumTerm(NT),
    .AcctW  (AW),
    .BalW   (BW),
    .NumAcct(10)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus)
  );

  logic [BW-1:0] mem [16];

  always @(posedge clock) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_addr];
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int            term;
    logic          op;
    logic [AW-1:0] id;
    logic [BW-1:0] val;
    logic [BW-1:0] exp_bal;
    logic          exp_err;
    logic          exp_rd;
    logic          exp_wr;
  } vec_t;

  vec_t vecs[9];

  task automatic drive_all(input logic [NT-1:0] r, input logic o, input logic [AW-1:0] id,
                           input logic [BW-1:0] v);
    bus.req = r;
    bus.op  = {NT{o}};
    for (int i = 0; i < int'(NT); i++) begin
      bus.req_id[i*AW +: AW]    = id;
      bus.req_value[i*BW +: BW] = v;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [NT-1:0] oh;
    oh = '0;
    oh[v.term] = 1'b1;
    @(negedge clock);
    drive_all(oh, v.op, v.id, v.val);
    @(negedge clock);  // RD
    check($sformatf("v%0d rd grant", n), int'(bus.grant), int'(oh));
    check($sformatf("v%0d rd_en", n), int'(bus.ram_rd_en), int'(v.exp_rd));
    if (v.exp_rd) check($sformatf("v%0d rd addr", n), int'(bus.ram_addr), int'(v.id));
    // Operands are frozen: drop and scramble everything mid-transaction.
    drive_all('0, ~v.op, '1, '1);
    @(negedge clock);  // EVAL
    check($sformatf("v%0d eval grant", n), int'(bus.grant), int'(oh));
    check($sformatf("v%0d eval rd_en", n), int'(bus.ram_rd_en), 0);
    @(negedge clock);  // WB
    check($sformatf("v%0d wr_en", n), int'(bus.ram_wr_en), int'(v.exp_wr));
    if (v.exp_wr) begin
      check($sformatf("v%0d wr addr", n), int'(bus.ram_addr), int'(v.id));
      check($sformatf("v%0d wr data", n), int'(bus.ram_wr_data), int'(v.exp_bal));
    end
    @(negedge clock);  // RSP
    check($sformatf("v%0d done", n), int'(bus.done), int'(oh));
    check($sformatf("v%0d balance", n), int'(bus.rsp_balance), int'(v.exp_bal));
    check($sformatf("v%0d err", n), int'(bus.rsp_err), int'(v.exp_err));
    @(negedge clock);  // IDLE
    check($sformatf("v%0d idle done", n), int'(bus.done), 0);
    check($sformatf("v%0d idle grant", n), int'(bus.grant), 0);
    if (v.exp_wr) check($sformatf("v%0d ram", n), int'(mem[v.id]), int'(v.exp_bal));
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int multi;
    bit t1_again;
    int d_term[$];
    int d_bal[$];
    int d_err[$];

    drive_all('0, 1'b0, '0, '0);
    mem = '{5'd1, 5'd2, 5'd4, 5'd20, 5'd10, 5'd12, 5'd6, 5'd7,
            5'd8, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};

    // term, op, id, val, exp_bal, exp_err, exp_rd, exp_wr
    vecs[0] = '{0, OpBalance, 4'd3,  5'd0,  5'd20, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1, OpDebit,   4'd5,  5'd7,  5'd5,  1'b0, 1'b1, 1'b1};
    vecs[2] = '{2, OpDebit,   4'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1};
    vecs[3] = '{3, OpDebit,   4'd2,  5'd9,  5'd4,  1'b1, 1'b1, 1'b0};
    vecs[4] = '{0, OpBalance, 4'd12, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, OpDebit,   4'd3,  5'd0,  5'd20, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{2, OpDebit,   4'd10, 5'd1,  5'd0,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{3, OpDebit,   4'd9,  5'd31, 5'd0,  1'b0, 1'b1, 1'b1};
    vecs[8] = '{0, OpBalance, 4'd5,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clock);
    check("reset grant", int'(bus.grant), 0);
    check("reset done", int'(bus.done), 0);
    check("reset rd/wr", int'({bus.ram_rd_en, bus.ram_wr_en}), 0);
    check("reset rsp", int'({bus.rsp_err, bus.rsp_balance}), 0);
`ifdef ATM_LEDGER_STATS_EN
    check("reset debit_count", int'(bus.debit_count), 0);
`endif
    clear_n = 1'b1;

    for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

    // Reset during WB: write must be abandoned, outputs cleared at once.
    @(negedge clock);
    drive_all(4'b0001, OpDebit, 4'd3, 5'd1);
    repeat (3) @(negedge clock);
    check("pre-reset wr_en", int'(bus.ram_wr_en), 1);
    clear_n = 1'b0;
    #1;
    check("async clr grant/done", int'({bus.grant, bus.done}), 0);
    check("async clr ram", int'({bus.ram_rd_en, bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data}), 0);
    check("async clr rsp", int'({bus.rsp_err, bus.rsp_balance}), 0);
    drive_all('0, 1'b0, '0, '0);
    @(negedge clock);
    check("reset no write", int'(mem[3]), 20);
    clear_n = 1'b1;
    @(negedge clock);
    check("post-reset idle", int'(bus.grant), 0);

    // Contention: all four request queries; terminal 1 re-requests once.
    for (int i = 0; i < int'(NT); i++) begin
      bus.req_id[i*AW +: AW] = AW'(i);
    end
    bus.op  = '0;
    bus.req = '1;
    multi = 0;
    t1_again = 1'b1;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      @(negedge clock);
      if (!$onehot0(bus.grant)) multi++;
      for (int i = 0; i < int'(NT); i++) begin
        if (bus.done[i]) begin
          order.push_back(i);
          if (i == 1 && t1_again) t1_again = 1'b0;
          else bus.req[i] = 1'b0;
        end
      end
    end
    exp_order = '{0, 1, 2, 3, 1};
    check("contention count", order.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("contention order[%0d]", k), (k < order.size()) ? order[k] : -1,
            exp_order[k]);
    end
    check("single grant", multi, 0);
    bus.req = '0;
    @(negedge clock);

    // Atomicity: terminals 1 and 2 both debit 6 from account 4 (balance 10).
    drive_all(4'b0110, OpDebit, 4'd4, 5'd6);
    for (int c = 0; c < 40 && d_term.size() < 2; c++) begin
      @(negedge clock);
      for (int i = 0; i < int'(NT); i++) begin
        if (bus.done[i]) begin
          d_term.push_back(i);
          d_bal.push_back(int'(bus.rsp_balance));
          d_err.push_back(int'(bus.rsp_err));
          bus.req[i] = 1'b0;
        end
      end
    end
    check("atomic count", d_term.size(), 2);
    if (d_term.size() == 2) begin
      check("atomic first term", d_term[0], 2);
      check("atomic first bal", d_bal[0], 4);
      check("atomic first err", d_err[0], 0);
      check("atomic second term", d_term[1], 1);
      check("atomic second bal", d_bal[1], 4);
      check("atomic second err", d_err[1], 1);
    end
    @(negedge clock);
    check("atomic ram", int'(mem[4]), 4);
`ifdef ATM_LEDGER_STATS_EN
    check("debit_count", int'(bus.debit_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
